i2c_master_byte_ctrl: RTL and testbench
=======================================

# i2c_master_byte_ctrl

Byte-level command sequencer of the I2C master core, directly upstream of the bit controller. It accepts START/STOP/READ/WRITE requests and a data byte from the register interface and expands them into a sequence of single-bit commands (`core_cmd`). It shifts transmit data out MSB-first and shifts received data in, and it handles the acknowledge bit. When the whole request is done it returns one `cmd_ack` pulse with the received byte and the slave acknowledge.

## Interface
- No parameters. Bit-command encoding is fixed: NOP=4'b0000, START=4'b0001, STOP=4'b0010, WRITE=4'b0100, READ=4'b1000.
- `clk` in 1: core clock. One clock domain only.
- `nReset` in 1: reset, synchronous, active-low.
- `start` in 1: generate a (repeated) START before the byte.
- `stop` in 1: generate a STOP after the byte/ack.
- `read` in 1: read one byte.
- `write` in 1: write one byte.
- `ack_in` in 1: acknowledge bit the master drives after a read (0=ACK, 1=NACK).
- `din` in 8: byte to transmit.
- `cmd_ack` out 1: one-cycle pulse when the request is complete.
- `ack_out` out 1: acknowledge bit received from the slave after a write.
- `dout` out 8: shift register contents. Holds the received byte after a read.
- `core_cmd` out 4: bit command to the bit controller.
- `core_txd` out 1: data bit for the bit controller's WRITE command.
- `core_ack` in 1: one-cycle pulse from the bit controller when the current bit command is done.
- `core_rxd` in 1: bit sampled by the bit controller during a READ.

## Operation
- `go = (start|stop|read|write) & ~cmd_ack`. The command inputs are sampled only in state IDLE. The host holds them until `cmd_ack` and clears them on it.
- Datapath registers:
  - `sr[7:0]` shift register; `dout = sr`.
  - `dcnt[2:0]` bit counter; `cnt_done = (dcnt==0)`.
  - Load: `sr<=din`, `dcnt<=7`.
  - Shift: `sr<={sr[6:0],core_rxd}`, `dcnt<=dcnt-1`.
- FSM states and transitions:
  - **IDLE**, on `go`:
    - `start` → START, `core_cmd`=START.
    - else `read` → READ, `core_cmd`=READ.
    - else `write` → WRITE, `core_cmd`=WRITE, `core_txd`=`din[7]`.
    - else → STOP, `core_cmd`=STOP.
    - Load in every case.
  - **START**, on `core_ack`:
    - `read` → READ, `core_cmd`=READ.
    - `write` → WRITE, `core_cmd`=WRITE, `core_txd`=`sr[7]`.
    - Neither set (start-only) → IDLE, `core_cmd`=NOP, `cmd_ack`=1.
    - Load on this transition.
  - **WRITE**, on `core_ack`:
    - Shift.
    - `cnt_done` → ACK, `core_cmd`=READ (sample slave ack).
    - else stay, `core_cmd`=WRITE, `core_txd`=`sr[6]` (next bit).
  - **READ**, on `core_ack`:
    - Shift.
    - `cnt_done` → ACK, `core_cmd`=WRITE, `core_txd`=`ack_in`.
    - else stay, `core_cmd`=READ.
  - **ACK**, on `core_ack`:
    - `ack_out<=core_rxd`.
    - `stop` → STOP, `core_cmd`=STOP.
    - else → IDLE, `core_cmd`=NOP, `cmd_ack`=1.
  - **STOP**, on `core_ack`: → IDLE, `core_cmd`=NOP, `cmd_ack`=1.
- `core_cmd` and `core_txd` are registered. They are held stable until the next `core_ack`.
- A `core_ack` received in IDLE is ignored.
- Priority on simultaneous requests: `start` before `read` before `write` before `stop`. `read` together with `write` performs a read. A sequence can chain START→byte→ACK→STOP in one request.
- Reset (`nReset` low at a clock edge), including mid-operation:
  - State goes to IDLE.
  - `core_cmd`=NOP, `core_txd`=0, `cmd_ack`=0, `ack_out`=0, `sr`=0, `dcnt`=0.
  - No `cmd_ack` is issued for the aborted request.

## Timing
- A request is issued 1 cycle after `go`: `core_cmd` is valid on the edge after `go` is sampled.
- Each following bit command is valid on the edge that samples `core_ack`, i.e. 0 idle cycles between bit commands. The bit controller needs ≥1 cycle between its ack and its next command sample, which a prescale ≥1 guarantees.
- `cmd_ack` is asserted on the edge that samples the final `core_ack`, for exactly 1 cycle. `dout` and `ack_out` are valid in that cycle and hold until the next load.
- Bit-command counts per request:
  - write = 9; read = 9.
  - +1 if `start`; +1 if `stop`.
  - start-only = 1; stop-only = 1.
- In IDLE, no new request is accepted in the cycle `cmd_ack` is high.

## Test plan
- **Write with start.** Bit-controller model acks after 5 cycles. Request start+write, `din`=8'hA5; model returns `core_rxd`=0 on the ack-read.
  - Required: `core_cmd` sequence START, then WRITE ×8 with `core_txd` 1,0,1,0,0,1,0,1, then READ, then NOP.
  - Single `cmd_ack` with `ack_out`=0.
- **Read with NACK and stop.** Request read+stop, `ack_in`=1; model returns `core_rxd` bits 0,0,1,1,1,1,0,0.
  - Required: READ ×8, then WRITE with `core_txd`=1, then STOP.
  - `cmd_ack` with `dout`=8'h3C.
- **Stop only.** Required: a single STOP, then `cmd_ack` 1 cycle after its `core_ack`; `dout` unchanged.
- **Back-to-back requests.** Host re-asserts write with `din`=8'hFF the cycle after `cmd_ack`.
  - Required: no command is issued during the `cmd_ack` cycle.
  - The new WRITE appears 1 cycle after acceptance, and `ack_out`=1 when the model returns 1.
- **Reset mid-byte.** Drop `nReset` for 1 cycle after the 4th WRITE ack.
  - Required: next edge has `core_cmd`=NOP, all outputs 0, state IDLE, no `cmd_ack`.
  - A following write of 8'h01 completes normally.
- **Priority.** Assert start+read+write.
  - Required: START followed by READ ×8, with no WRITE data bits.

Source files
------------

// File: rtl/i2c_master_byte_ctrl.sv
// I2C byte controller: turns START/STOP/READ/WRITE byte requests into
// single-bit commands for the bit controller, shifting data MSB-first.
module i2c_master_byte_ctrl (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       read_i,
  input  logic       write_i,
  input  logic       ack_in_i,
  input  logic [7:0] din_i,
  output logic       cmd_ack_o,
  output logic       ack_out_o,
  output logic [7:0] dout_o,
  output logic [3:0] core_cmd_o,
  output logic       core_txd_o,
  input  logic       core_ack_i,
  input  logic       core_rxd_i
);

  localparam logic [3:0] CMD_NOP   = 4'b0000;
  localparam logic [3:0] CMD_START = 4'b0001;
  localparam logic [3:0] CMD_STOP  = 4'b0010;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_READ, ST_WRITE, ST_ACK, ST_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] dcnt_q, dcnt_d;
  logic [3:0] core_cmd_q, core_cmd_d;
  logic       core_txd_q, core_txd_d;
  logic       cmd_ack_q, cmd_ack_d;
  logic       ack_out_q, ack_out_d;
  logic       load, shift, go, cnt_done;

  // A request is still asserted during the cmd_ack cycle; mask it so it is not re-run.
  assign go       = (start_i | stop_i | read_i | write_i) & ~cmd_ack_q;
  assign cnt_done = (dcnt_q == 3'd0);

  always_comb begin
    state_d    = state_q;
    core_cmd_d = core_cmd_q;
    core_txd_d = core_txd_q;
    cmd_ack_d  = 1'b0;
    ack_out_d  = ack_out_q;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          load = 1'b1;
          if (start_i) begin
            state_d    = ST_START;
            core_cmd_d = CMD_START;
          end else if (read_i) begin
            state_d    = ST_READ;
            core_cmd_d = CMD_READ;
          end else if (write_i) begin
            state_d    = ST_WRITE;
            core_cmd_d = CMD_WRITE;
            core_txd_d = din_i[7];
          end else begin
            state_d    = ST_STOP;
            core_cmd_d = CMD_STOP;
          end
        end
      end
      ST_START: begin
        if (core_ack_i) begin
          load = 1'b1;
          if (read_i) begin
            state_d    = ST_READ;
            core_cmd_d = CMD_READ;
          end else if (write_i) begin
            state_d    = ST_WRITE;
            core_cmd_d = CMD_WRITE;
            core_txd_d = sr_q[7];
          end else begin
            state_d    = ST_IDLE;
            core_cmd_d = CMD_NOP;
            cmd_ack_d  = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (core_ack_i) begin
          shift = 1'b1;
          if (cnt_done) begin
            state_d    = ST_ACK;
            core_cmd_d = CMD_READ;
          end else begin
            core_cmd_d = CMD_WRITE;
            core_txd_d = sr_q[6];
          end
        end
      end
      ST_READ: begin
        if (core_ack_i) begin
          shift = 1'b1;
          if (cnt_done) begin
            state_d    = ST_ACK;
            core_cmd_d = CMD_WRITE;
            core_txd_d = ack_in_i;
          end else begin
            core_cmd_d = CMD_READ;
          end
        end
      end
      ST_ACK: begin
        if (core_ack_i) begin
          ack_out_d = core_rxd_i;
          if (stop_i) begin
            state_d    = ST_STOP;
            core_cmd_d = CMD_STOP;
          end else begin
            state_d    = ST_IDLE;
            core_cmd_d = CMD_NOP;
            cmd_ack_d  = 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (core_ack_i) begin
          state_d    = ST_IDLE;
          core_cmd_d = CMD_NOP;
          cmd_ack_d  = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        core_cmd_d = CMD_NOP;
      end
    endcase
  end

  always_comb begin
    sr_d   = sr_q;
    dcnt_d = dcnt_q;
    if (load) begin
      sr_d   = din_i;
      dcnt_d = 3'd7;
    end else if (shift) begin
      sr_d   = {sr_q[6:0], core_rxd_i};
      dcnt_d = dcnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q    <= ST_IDLE;
      sr_q       <= 8'h00;
      dcnt_q     <= 3'd0;
      core_cmd_q <= CMD_NOP;
      core_txd_q <= 1'b0;
      cmd_ack_q  <= 1'b0;
      ack_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      dcnt_q     <= dcnt_d;
      core_cmd_q <= core_cmd_d;
      core_txd_q <= core_txd_d;
      cmd_ack_q  <= cmd_ack_d;
      ack_out_q  <= ack_out_d;
    end
  end

  assign cmd_ack_o  = cmd_ack_q;
  assign ack_out_o  = ack_out_q;
  assign dout_o     = sr_q;
  assign core_cmd_o = core_cmd_q;
  assign core_txd_o = core_txd_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Directed bench for i2c_master_byte_ctrl with a bit-controller model that
// acknowledges every bit command 5 cycles after it appears.
module tb_i2c_master_byte_ctrl;

  localparam logic [3:0] NOP   = 4'b0000;
  localparam logic [3:0] START = 4'b0001;
  localparam logic [3:0] STOP  = 4'b0010;
  localparam logic [3:0] WRITE = 4'b0100;
  localparam logic [3:0] READ  = 4'b1000;

  logic       clk = 1'b0;
  logic       nreset, req_start, req_stop, req_rd, req_wr, ack_in;
  logic [7:0] din;
  logic       cmd_ack, ack_out, core_txd;
  logic [7:0] dout;
  logic [3:0] core_cmd;
  logic       core_ack = 1'b0;
  logic       core_rxd = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2c_master_byte_ctrl dut (
    .clk_i(clk), .nreset_i(nreset), .start_i(req_start), .stop_i(req_stop),
    .read_i(req_rd), .write_i(req_wr), .ack_in_i(ack_in), .din_i(din),
    .cmd_ack_o(cmd_ack), .ack_out_o(ack_out), .dout_o(dout),
    .core_cmd_o(core_cmd), .core_txd_o(core_txd),
    .core_ack_i(core_ack), .core_rxd_i(core_rxd)
  );

  int cyc = 0;
  int pulses = 0;
  always @(posedge clk) begin
    cyc++;
    if (cmd_ack === 1'b1) pulses++;
  end

  // Bit-controller model: logs each command when acknowledging it.
  logic       model_en = 1'b0;
  int         mcnt = 0;
  logic       rxq[$];
  logic [3:0] log_cmd[0:127];
  logic       log_txd[0:127];
  int         log_n = 0;
  int         last_ack_cyc = -10;

  always @(negedge clk) begin
    core_ack = 1'b0;
    if (!model_en || core_cmd == NOP) begin
      mcnt = 0;
    end else begin
      mcnt++;
      if (mcnt == 5) begin
        mcnt     = 0;
        core_ack = 1'b1;
        core_rxd = 1'b0;
        if (core_cmd == READ && rxq.size() > 0) core_rxd = rxq.pop_front();
        if (log_n < 128) begin
          log_cmd[log_n] = core_cmd;
          log_txd[log_n] = core_txd;
          log_n++;
        end
        last_ack_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd_ack(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cmd_ack === 1'b1) return;
    end
    chk({tag, "_timeout"}, {31'd0, cmd_ack}, 32'd1);
  endtask

  task automatic set_req(input logic s, input logic p, input logic r, input logic w,
                         input logic [7:0] d, input logic ai);
    req_start = s; req_stop = p; req_rd = r; req_wr = w; din = d; ack_in = ai;
  endtask

  initial begin
    int base, p0;
    logic [7:0] v;
    set_req(0, 0, 0, 0, 8'h00, 0);
    nreset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd", {28'd0, core_cmd}, {28'd0, NOP});
    chk("rst_txd", {31'd0, core_txd}, 32'd0);
    chk("rst_cmd_ack", {31'd0, cmd_ack}, 32'd0);
    chk("rst_ack_out", {31'd0, ack_out}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    nreset = 1'b1;
    model_en = 1'b1;
    @(negedge clk);

    // Write with start, din=A5, slave ACKs
    base = log_n; p0 = pulses;
    set_req(1, 0, 0, 1, 8'hA5, 0);
    wait_cmd_ack("wr_start");
    chk("wr_ack_out", {31'd0, ack_out}, 32'd0);
    set_req(0, 0, 0, 0, 8'h00, 0);
    @(negedge clk);
    chk("wr_cmd_ack_width", {31'd0, cmd_ack}, 32'd0);
    chk("wr_cmd_nop", {28'd0, core_cmd}, {28'd0, NOP});
    @(negedge clk);
    chk("wr_pulses", pulses - p0, 32'd1);
    chk("wr_count", log_n - base, 32'd10);
    chk("wr_first_start", {28'd0, log_cmd[base]}, {28'd0, START});
    v = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wr_bit%0d_cmd", i), {28'd0, log_cmd[base+1+i]}, {28'd0, WRITE});
      chk($sformatf("wr_bit%0d_txd", i), {31'd0, log_txd[base+1+i]}, {31'd0, v[7-i]});
    end
    chk("wr_ackread", {28'd0, log_cmd[base+9]}, {28'd0, READ});

    // Read with NACK and stop, slave returns 3C
    v = 8'h3C;
    for (int i = 7; i >= 0; i--) rxq.push_back(v[i]);
    base = log_n; p0 = pulses;
    set_req(0, 1, 1, 0, 8'h00, 1);
    wait_cmd_ack("rd_stop");
    chk("rd_dout", {24'd0, dout}, 32'h3C);
    set_req(0, 0, 0, 0, 8'h00, 0);
    repeat (2) @(negedge clk);
    chk("rd_pulses", pulses - p0, 32'd1);
    chk("rd_count", log_n - base, 32'd10);
    for (int i = 0; i < 8; i++)
      chk($sformatf("rd_bit%0d_cmd", i), {28'd0, log_cmd[base+i]}, {28'd0, READ});
    chk("rd_ack_cmd", {28'd0, log_cmd[base+8]}, {28'd0, WRITE});
    chk("rd_ack_txd", {31'd0, log_txd[base+8]}, 32'd1);
    chk("rd_stop_cmd", {28'd0, log_cmd[base+9]}, {28'd0, STOP});

    // Stop only (din kept equal to the held byte so dout is unchanged)
    base = log_n; p0 = pulses;
    set_req(0, 1, 0, 0, 8'h3C, 0);
    wait_cmd_ack("stop_only");
    chk("stop_ack_latency", cyc - last_ack_cyc, 32'd1);
    chk("stop_dout", {24'd0, dout}, 32'h3C);
    chk("stop_count", log_n - base, 32'd1);
    chk("stop_cmd", {28'd0, log_cmd[base]}, {28'd0, STOP});

    // Back-to-back write FF, asserted during the cmd_ack cycle; slave NACKs
    rxq.push_back(1'b1);
    base = log_n;
    set_req(0, 0, 0, 1, 8'hFF, 0);
    @(negedge clk);
    chk("b2b_no_cmd_in_ack_cycle", {28'd0, core_cmd}, {28'd0, NOP});
    @(negedge clk);
    chk("b2b_write_cmd", {28'd0, core_cmd}, {28'd0, WRITE});
    chk("b2b_write_txd", {31'd0, core_txd}, 32'd1);
    wait_cmd_ack("b2b");
    chk("b2b_ack_out", {31'd0, ack_out}, 32'd1);
    chk("b2b_count", log_n - base, 32'd9);
    set_req(0, 0, 0, 0, 8'h00, 0);
    repeat (2) @(negedge clk);
    chk("b2b_pulses", pulses - p0, 32'd2);

    // Reset after the 4th WRITE ack of a byte
    base = log_n;
    set_req(0, 0, 0, 1, 8'h5A, 0);
    for (int i = 0; i < 200 && log_n < base + 4; i++) @(posedge clk);
    chk("rstmid_reached", log_n - base, 32'd4);
    @(negedge clk);
    nreset = 1'b0;
    model_en = 1'b0;
    set_req(0, 0, 0, 0, 8'h00, 0);
    p0 = pulses;
    @(negedge clk);
    chk("rstmid_cmd", {28'd0, core_cmd}, {28'd0, NOP});
    chk("rstmid_txd", {31'd0, core_txd}, 32'd0);
    chk("rstmid_cmd_ack", {31'd0, cmd_ack}, 32'd0);
    chk("rstmid_ack_out", {31'd0, ack_out}, 32'd0);
    chk("rstmid_dout", {24'd0, dout}, 32'd0);
    chk("rstmid_state", {29'd0, dut.state_q}, 32'd0);
    chk("rstmid_dcnt", {29'd0, dut.dcnt_q}, 32'd0);
    nreset = 1'b1;
    model_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid_no_cmd_ack", pulses - p0, 32'd0);

    // Write 01 after the reset completes normally
    base = log_n; p0 = pulses;
    set_req(0, 0, 0, 1, 8'h01, 0);
    wait_cmd_ack("wr01");
    chk("wr01_ack_out", {31'd0, ack_out}, 32'd0);
    set_req(0, 0, 0, 0, 8'h00, 0);
    repeat (2) @(negedge clk);
    chk("wr01_pulses", pulses - p0, 32'd1);
    chk("wr01_count", log_n - base, 32'd9);
    v = 8'h01;
    for (int i = 0; i < 8; i++)
      chk($sformatf("wr01_bit%0d_txd", i), {31'd0, log_txd[base+i]}, {31'd0, v[7-i]});
    chk("wr01_ackread", {28'd0, log_cmd[base+8]}, {28'd0, READ});

    // Priority: start+read+write performs START then a read
    v = 8'h96;
    for (int i = 7; i >= 0; i--) rxq.push_back(v[i]);
    base = log_n;
    set_req(1, 0, 1, 1, 8'h00, 0);
    wait_cmd_ack("prio");
    chk("prio_dout", {24'd0, dout}, 32'h96);
    set_req(0, 0, 0, 0, 8'h00, 0);
    repeat (2) @(negedge clk);
    chk("prio_count", log_n - base, 32'd10);
    chk("prio_start", {28'd0, log_cmd[base]}, {28'd0, START});
    for (int i = 1; i <= 8; i++)
      chk($sformatf("prio_bit%0d_cmd", i), {28'd0, log_cmd[base+i]}, {28'd0, READ});
    chk("prio_ack_cmd", {28'd0, log_cmd[base+9]}, {28'd0, WRITE});
    chk("prio_ack_txd", {31'd0, log_txd[base+9]}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
